leading_zero: RTL and testbench
===============================

// Module: leading_zero
// PURPOSE
//  - Registered leading-zero counter for the FPU unpacker.
//  - Counts consecutive 0 bits in x, starting at the MSB, and returns the count on y.
//  - The mantissa normalisation shift uses y.
//  - Combinational tree priority encoder followed by one output register stage.
// PARAMETERS
//  - n   default 32   input width; power of two, 2..64; y width = $clog2(n)+1
// PORTS
//  - clk       input   1               clock; all state updates on rising edge
//  - rst_n     input   1               reset, asynchronous, active-low
//  - in_valid  input   1               x is valid this cycle
//  - x         input   n               operand
//  - out_valid output  1               y is valid this cycle
//  - y         output  $clog2(n)+1     leading-zero count, range 0..n
//  - zero      output  1               x was all zeros (only with LZC_ZERO_FLAG_EN)
// BEHAVIOUR
//  - Reset: one clock, clk. rst_n is asynchronous and active-low.
//    - While rst_n=0: y=0, out_valid=0, zero=0, held regardless of clk.
//    - Deassertion is synchronised outside this block.
//  - Count definition:
//    - y = index distance from bit n-1 to the highest set bit, i.e. (n-1) - msb_index(x).
//    - x == 0 gives y = n; the MSB of y is set only in that case.
//    - x[n-1] == 1 gives y = 0, independent of the lower bits.
//  - Structure:
//    - Recursive/tree LZC with log2(n) levels.
//    - Each node merges a left count/all-zero pair with a right count/all-zero pair:
//      - left not all-zero: count = {0, left_cnt}
//      - left all-zero: count = {right_allzero, 1, right_cnt} as appropriate
//    - No linear priority chain.
//  - Latency: exactly 1 cycle.
//    - in_valid/x sampled at rising edge k; y/out_valid valid after edge k, for cycle k+1.
//  - Handshake:
//    - No backpressure; a new operand is accepted every cycle.
//    - out_valid <= in_valid each cycle.
//    - y is loaded only when in_valid=1; otherwise it holds its last value.
//  - Back-to-back valid inputs give back-to-back results, with no bubbles.
//  - Reset mid-operation: the in-flight result is discarded; out_valid=0 on the first cycle after release.
//  - X on x while in_valid=0 must not propagate to y.
// CONFIGURATION
//  - Macro LZC_ZERO_FLAG_EN.
//  - Defined:
//    - Output port zero exists.
//    - zero is registered alongside y with the same latency and the same load enable.
//    - zero=1 iff the sampled x==0; reset value 0.
//  - Undefined:
//    - Port zero is absent.
//    - The all-zero condition is still indicated by y==n.
// TESTING (n=32; each check one cycle after in_valid=1)
//  - x=32'h00000000 -> y=32 (zero=1 if enabled); x=32'hFFFFFFFF -> y=0.
//  - x=32'h80000000 -> y=0; x=32'h00008000 -> y=16; x=32'h00000001 -> y=31.
//  - x=32'h000000FF -> y=24; x=32'h00003FFF -> y=18; x=32'h000FFFFF -> y=12.
//  - Stream all 33 single-bit/zero patterns on consecutive cycles -> y sequence 0..32, out_valid held 1.
//  - in_valid=0 with x changing -> y holds, out_valid=0.
//  - Assert rst_n=0 mid-stream, asynchronously between edges -> y=0 and out_valid=0 immediately.

Source files
------------

// File: rtl/leading_zero_if.sv
// Operand/result bundle for the leading-zero counter.
// The zero flag exists only when LZC_ZERO_FLAG_EN is defined.
interface leading_zero_if #(
   parameter int unsigned n = 32
);
   localparam int unsigned YW = $clog2(n) + 1;

   logic          in_valid;
   logic [n-1:0]  x;
   logic          out_valid;
   logic [YW-1:0] y;
`ifdef LZC_ZERO_FLAG_EN
   logic          zero;

   modport master (output in_valid, output x, input out_valid, input y, input zero);
   modport slave  (input in_valid, input x, output out_valid, output y, output zero);
`else
   modport master (output in_valid, output x, input out_valid, input y);
   modport slave  (input in_valid, input x, output out_valid, output y);
`endif
endinterface

// File: rtl/leading_zero.sv
// Registered tree leading-zero counter for the FPU unpacker (one-cycle latency).
// Optional registered all-zero flag enabled by macro LZC_ZERO_FLAG_EN.
module leading_zero #(
   parameter int unsigned n = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   leading_zero_if.slave bus
);
   localparam int unsigned LW = $clog2(n);
   localparam int unsigned YW = LW + 1;

   logic          out_valid_q, out_valid_d;
   logic [YW-1:0] y_q, y_d;
   logic [YW-1:0] cnt_c;

   // Tree encoder: slot 0 holds the MSB; each level merges sibling pairs in place
   always_comb begin
      logic [n-1:0]  az;
      logic [LW-1:0] cnt [n];
      for (int i = 0; i < int'(n); i++) begin
         az[i]  = ~bus.x[n-1-i];
         cnt[i] = '0;
      end
      for (int l = 1; l <= int'(LW); l++) begin
         for (int j = 0; j < int'(n >> l); j++) begin
            if (az[2*j]) begin
               cnt[j] = LW'(1 << (l - 1)) | cnt[2*j+1];
            end else begin
               cnt[j] = cnt[2*j];
            end
            az[j] = az[2*j] & az[2*j+1];
         end
      end
      cnt_c = az[0] ? YW'(n) : {1'b0, cnt[0]};
   end

   always_comb begin
      out_valid_d = bus.in_valid;
      y_d         = y_q;
      if (bus.in_valid) begin
         y_d = cnt_c;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         y_q         <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         y_q         <= y_d;
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.y         = y_q;

`ifdef LZC_ZERO_FLAG_EN
   logic zero_q, zero_d;

   // Same load enable as y so the flag always describes the held count
   always_comb begin
      zero_d = zero_q;
      if (bus.in_valid) begin
         zero_d = cnt_c[YW-1];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         zero_q <= 1'b0;
      end else begin
         zero_q <= zero_d;
      end
   end

   assign bus.zero = zero_q;
`endif
endmodule

// File: tb/tb_leading_zero.sv
// Directed scoreboard bench for leading_zero at n=32.
module tb_leading_zero;
   localparam int unsigned N  = 32;
   localparam int unsigned YW = $clog2(N) + 1;

   typedef struct {
      logic          v;
      logic [YW-1:0] y;
      logic          z;
   } exp_t;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_fail;

   exp_t          exp_q[$];
   logic [YW-1:0] last_y;
   logic          last_z;

   leading_zero_if #(.n(N)) bus ();

   leading_zero #(.n(N)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_outputs(input string tag, input logic v, input logic [YW-1:0] y, input logic z);
      chk({tag, ".out_valid"}, 64'(bus.out_valid), 64'(v));
      chk({tag, ".y"}, 64'(bus.y), 64'(y));
`ifdef LZC_ZERO_FLAG_EN
      chk({tag, ".zero"}, 64'(bus.zero), 64'(z));
`else
      if (z) chk({tag, ".y_all_zero"}, 64'(bus.y), 64'(N));
`endif
   endtask

   // Called at a falling edge: drive, push expectation, check one cycle later
   task automatic step(input string tag, input logic v, input logic [N-1:0] xv,
                       input logic [YW-1:0] ey);
      exp_t e;
      bus.in_valid = v;
      bus.x        = xv;
      if (v) begin
         last_y = ey;
         last_z = (xv == '0);
      end
      exp_q.push_back('{v: v, y: last_y, z: last_z});
      @(negedge clk);
      if (exp_q.size() == 0) begin
         chk({tag, ".scoreboard_empty"}, 64'd1, 64'd0);
      end else begin
         e = exp_q.pop_front();
         chk_outputs(tag, e.v, e.y, e.z);
      end
   endtask

   initial begin
      logic [N-1:0] pat;
      n_checks     = 0;
      n_fail       = 0;
      last_y       = '0;
      last_z       = 1'b0;
      rst_n        = 1'b0;
      bus.in_valid = 1'b0;
      bus.x        = '0;

      #2;
      chk_outputs("reset", 1'b0, '0, 1'b0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      step("all_zero", 1'b1, 32'h0000_0000, 6'd32);
      step("all_ones", 1'b1, 32'hFFFF_FFFF, 6'd0);
      step("msb",      1'b1, 32'h8000_0000, 6'd0);
      step("bit15",    1'b1, 32'h0000_8000, 6'd16);
      step("lsb",      1'b1, 32'h0000_0001, 6'd31);
      step("low_byte", 1'b1, 32'h0000_00FF, 6'd24);
      step("mask14",   1'b1, 32'h0000_3FFF, 6'd18);
      step("mask20",   1'b1, 32'h000F_FFFF, 6'd12);
      step("msb_mix",  1'b1, 32'hA5A5_A5A5, 6'd0);
      step("mid_mix",  1'b1, 32'h0012_3456, 6'd11);

      for (int i = 0; i <= 32; i++) begin
         pat = (i < 32) ? (32'h8000_0000 >> i) : 32'h0;
         step($sformatf("stream%0d", i), 1'b1, pat, YW'(i));
      end

      step("idle_a", 1'b0, 32'h0000_0001, 6'd0);
      step("idle_b", 1'b0, 32'hFFFF_FFFF, 6'd0);
      step("idle_x", 1'b0, 'x, 6'd0);
      step("resume", 1'b1, 32'h0000_0400, 6'd21);

      // Async reset between edges with a result and a new operand in flight
      bus.in_valid = 1'b1;
      bus.x        = 32'h0000_0100;
      @(posedge clk);
      #2;
      chk_outputs("pre_rst", 1'b1, 6'd23, 1'b0);
      rst_n = 1'b0;
      #1;
      chk_outputs("async_rst", 1'b0, '0, 1'b0);
      exp_q.delete();
      last_y = '0;
      last_z = 1'b0;
      @(negedge clk);
      chk_outputs("rst_hold", 1'b0, '0, 1'b0);
      rst_n        = 1'b1;
      bus.in_valid = 1'b0;
      step("post_rst", 1'b0, 32'h0000_0100, 6'd0);
      step("post_rst_valid", 1'b1, 32'h0001_0000, 6'd15);
      step("post_rst_zero", 1'b1, 32'h0000_0000, 6'd32);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
